// File: rtl/cnn_pkg.sv
// Shared constants for the CNN result reporting path: ASCII codes,
// reporting FSM state encoding and the default UART bit period.
package cnn_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  // 50 MHz system clock, 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_SEND_CHAR = 3'd2;
  localparam logic [2:0] ST_SEND_CR   = 3'd3;
  localparam logic [2:0] ST_SEND_LF   = 3'd4;

  // Classes 0..9 print as their decimal digit; anything else is not a
  // valid class for this network and prints as '?'
  function automatic logic [7:0] classToAscii(input logic [3:0] cls);
    if (cls <= 4'd9) begin
      return ASCII_ZERO + {4'd0, cls};
    end
    return ASCII_QMARK;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter. A start pulse loads a byte and sends
// start bit, 8 data bits LSB first and a stop bit. done is high in the
// final cycle of the stop bit so a caller can chain frames with no gap.
module uart_tx_byte
  import cnn_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic          r_active;
  logic [BW-1:0] r_baudCnt;
  logic [3:0]    r_bitCnt;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic w_bitEnd;
  logic w_lastBit;

  assign w_bitEnd  = r_active && (r_baudCnt == BAUD_LAST);
  assign w_lastBit = (r_bitCnt == 4'd9);
  assign done      = w_bitEnd && w_lastBit;
  assign tx        = r_tx;

  // Bit sequencing: bit index 0 is the start bit, 1..8 data, 9 stop.
  // Ones are shifted in so the stop bit falls out of the shifter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active  <= 1'b0;
      r_baudCnt <= '0;
      r_bitCnt  <= 4'd0;
      r_shift   <= 8'd0;
      r_tx      <= 1'b1;
    end else if (start) begin
      r_active  <= 1'b1;
      r_baudCnt <= '0;
      r_bitCnt  <= 4'd0;
      r_shift   <= data;
      r_tx      <= 1'b0;
    end else if (r_active) begin
      if (w_bitEnd) begin
        r_baudCnt <= '0;
        if (w_lastBit) begin
          r_active <= 1'b0;
          r_tx     <= 1'b1;
        end else begin
          r_bitCnt <= r_bitCnt + 4'd1;
          r_tx     <= r_shift[0];
          r_shift  <= {1'b1, r_shift[7:1]};
        end
      end else begin
        r_baudCnt <= r_baudCnt + BW'(1);
      end
    end
  end

endmodule

// File: rtl/cnn_result_uart.sv
// Reporting stage for the CNN classifier: queues each finished class
// index and prints it on the UART as "<digit>\r\n". Keeps a count of
// accepted results and a sticky flag for results lost to a full queue.
module cnn_result_uart
  import cnn_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        finish,
  input  logic [3:0]  class_out,
  output logic        uart_tx,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] result_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [3:0]  r_fifoMem [FIFO_DEPTH];
  logic [AW:0] r_wrPtr;
  logic [AW:0] r_rdPtr;
  logic [2:0]  r_state;
  logic        r_overflow;
  logic [15:0] r_resultCount;

  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_drop;
  logic [3:0]  w_head;
  logic [2:0]  w_nextState;
  logic        w_byteStart;
  logic [7:0]  w_byteData;
  logic        w_byteDone;

  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                   (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_pop   = (r_state == ST_LOAD) && !w_empty;
  assign w_push  = finish && (!w_full || w_pop);
  assign w_drop  = finish && w_full && !w_pop;
  assign w_head  = r_fifoMem[r_rdPtr[AW-1:0]];

  assign busy         = (r_state != ST_IDLE) || !w_empty;
  assign overflow     = r_overflow;
  assign result_count = r_resultCount;

  // Queue storage; stale contents are harmless since pointers gate reads
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoMem[r_wrPtr[AW-1:0]] <= class_out;
    end
  end

  // Queue pointers, accepted-result counter and sticky drop flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_resultCount <= 16'd0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr       <= r_wrPtr + 1'b1;
        r_resultCount <= r_resultCount + 16'd1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Next-state logic. IDLE also reacts to an incoming finish so the
  // result is loaded the cycle its queue entry becomes visible.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:      if (!w_empty || finish) w_nextState = ST_LOAD;
      ST_LOAD:      w_nextState = ST_SEND_CHAR;
      ST_SEND_CHAR: if (w_byteDone) w_nextState = ST_SEND_CR;
      ST_SEND_CR:   if (w_byteDone) w_nextState = ST_SEND_LF;
      ST_SEND_LF:   if (w_byteDone) w_nextState = w_empty ? ST_IDLE : ST_LOAD;
      default:      w_nextState = ST_IDLE;
    endcase
  end

  // Byte engine kick-off: the next frame starts in the done cycle of the
  // previous one so the three frames of a result are back-to-back
  always_comb begin
    w_byteStart = 1'b0;
    w_byteData  = 8'h00;
    case (r_state)
      ST_LOAD: begin
        w_byteStart = 1'b1;
        w_byteData  = classToAscii(w_head);
      end
      ST_SEND_CHAR: begin
        w_byteStart = w_byteDone;
        w_byteData  = ASCII_CR;
      end
      ST_SEND_CR: begin
        w_byteStart = w_byteDone;
        w_byteData  = ASCII_LF;
      end
      default: begin
        w_byteStart = 1'b0;
        w_byteData  = 8'h00;
      end
    endcase
  end

  // Reporting FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_txByte (
    .clk  (clk),
    .reset(reset),
    .start(w_byteStart),
    .data (w_byteData),
    .tx   (uart_tx),
    .done (w_byteDone)
  );

endmodule

// File: tb/tb_cnn_result_uart.sv
// Directed bench for cnn_result_uart with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A line decoder turns uart_tx back into bytes for comparison.
module tb_cnn_result_uart;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        finish;
  logic [3:0]  class_out;
  logic        uart_tx;
  logic        busy;
  logic        overflow;
  logic [15:0] result_count;

  int testCount = 0;
  int failCount = 0;
  int cycleNum = 0;
  int firstLowCycle = -1;
  int lastBusyCycle = -1;
  int finishCycle = 0;
  int frameErrors = 0;
  bit rxActive = 1'b0;
  int rxCnt = 0;
  int rxBit = 0;
  logic [7:0] rxByte = 8'h00;
  logic [7:0] rxQ [$];
  logic [3:0] stimClasses [8];

  cnn_result_uart #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .finish      (finish),
    .class_out   (class_out),
    .uart_tx     (uart_tx),
    .busy        (busy),
    .overflow    (overflow),
    .result_count(result_count)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  // Cycle index, read by stimulus and decoder
  always @(posedge clk) cycleNum <= cycleNum + 1;

  // Line decoder sampling mid-bit on the falling edge; reset drops any partial frame
  always @(negedge clk) begin
    if (reset) begin
      rxActive = 1'b0;
    end else if (!rxActive) begin
      if (uart_tx === 1'b0) begin
        rxActive = 1'b1;
        rxCnt = 0;
        if (firstLowCycle < 0) firstLowCycle = cycleNum;
      end
    end else begin
      rxCnt++;
      if (rxCnt % CPB == CPB / 2) begin
        rxBit = rxCnt / CPB;
        if (rxBit == 0) begin
          if (uart_tx !== 1'b0) frameErrors++;
        end else if (rxBit <= 8) begin
          rxByte[rxBit-1] = uart_tx;
        end else begin
          if (uart_tx !== 1'b1) frameErrors++;
          rxQ.push_back(rxByte);
          rxActive = 1'b0;
        end
      end
    end
    if (busy) lastBusyCycle = cycleNum;
  end

  // Run-away guard
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Pulse finish in n consecutive cycles using stimClasses[0..n-1]
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      finish = 1'b1;
      class_out = stimClasses[i];
      if (i == 0) finishCycle = cycleNum;
    end
    @(posedge clk);
    #1;
    finish = 1'b0;
    class_out = 4'd0;
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rxQ.delete();
    frameErrors = 0;
    firstLowCycle = -1;
  endtask

  task automatic waitIdle(input string tag);
    int k;
    k = 0;
    while ((busy || rxActive) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  // Compare decoded bytes against a hand-written expected string, then clear
  task automatic checkRx(input string tag, input string exp);
    logic [7:0] got;
    checkOutput({tag, "_len"}, rxQ.size(), exp.len());
    for (int i = 0; i < exp.len(); i++) begin
      got = (i < rxQ.size()) ? rxQ[i] : 8'h00;
      checkOutput($sformatf("%s_byte%0d", tag, i), {24'd0, got}, {24'd0, exp[i]});
    end
    checkOutput({tag, "_frameErr"}, frameErrors, 0);
    rxQ.delete();
    frameErrors = 0;
  endtask

  initial begin
    reset = 1'b1;
    finish = 1'b0;
    class_out = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    $display("[TB] reset values");
    checkOutput("rst_tx", {31'd0, uart_tx}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("rst_count", {16'd0, result_count}, 32'd0);

    $display("[TB] single result, class 7");
    firstLowCycle = -1;
    stimClasses = '{4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    applyStimulus(1);
    checkOutput("t1_count", {16'd0, result_count}, 32'd1);
    waitIdle("t1");
    checkOutput("t1_firstLow", firstLowCycle - finishCycle, 32'd2);
    checkOutput("t1_lastBusy", lastBusyCycle - finishCycle, 32'd121);
    checkRx("t1", "7\r\n");

    $display("[TB] invalid class 12");
    stimClasses = '{4'd12, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    applyStimulus(1);
    checkOutput("t2_count", {16'd0, result_count}, 32'd2);
    waitIdle("t2");
    checkRx("t2", "?\r\n");

    $display("[TB] burst of 5");
    applyReset();
    stimClasses = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd0, 4'd0};
    applyStimulus(5);
    checkOutput("t3_count", {16'd0, result_count}, 32'd5);
    checkOutput("t3_overflow", {31'd0, overflow}, 32'd0);
    waitIdle("t3");
    checkRx("t3", "1\r\n2\r\n3\r\n4\r\n5\r\n");
    checkOutput("t3_overflowEnd", {31'd0, overflow}, 32'd0);

    $display("[TB] overflow with 7 pulses");
    applyReset();
    stimClasses = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
    applyStimulus(7);
    checkOutput("t4_overflow", {31'd0, overflow}, 32'd1);
    checkOutput("t4_count", {16'd0, result_count}, 32'd5);
    waitIdle("t4");
    checkRx("t4", "3\r\n4\r\n5\r\n6\r\n7\r\n");
    checkOutput("t4_overflowSticky", {31'd0, overflow}, 32'd1);

    $display("[TB] reset during CR frame");
    stimClasses = '{4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    applyStimulus(1);
    // CR frame starts 42 cycles after finish; bit 4 spans +58..+61
    repeat (58) @(posedge clk);
    #1;
    checkOutput("t5_busyBefore", {31'd0, busy}, 32'd1);
    checkOutput("t5_charBefore", rxQ.size(), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("t5_tx", {31'd0, uart_tx}, 32'd1);
    checkOutput("t5_busy", {31'd0, busy}, 32'd0);
    checkOutput("t5_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("t5_count", {16'd0, result_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rxQ.delete();
    frameErrors = 0;
    repeat (20) @(negedge clk);
    checkOutput("t5_txIdle", {31'd0, uart_tx}, 32'd1);
    checkOutput("t5_noResume", rxQ.size(), 32'd0);
    stimClasses = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    applyStimulus(1);
    waitIdle("t5");
    checkRx("t5", "0\r\n");

    $display("[TB] result_count wrap");
    @(posedge clk);
    #1;
    force dut.r_resultCount = 16'hFFFF;
    @(negedge clk);
    release dut.r_resultCount;
    @(negedge clk);
    checkOutput("t6_preload", {16'd0, result_count}, 32'hFFFF);
    stimClasses = '{4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    applyStimulus(1);
    checkOutput("t6_count", {16'd0, result_count}, 32'd0);
    waitIdle("t6");
    checkRx("t6", "9\r\n");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
